// File: rtl/bounce_gen.sv
// -----------------------------------------------------------------------------
// bounce_gen -- mechanical-switch emulator (transmit-side twin of a debouncer)
//
// On a start request the single-bit switch line is walked from its current
// level to the requested target through an odd number of toggles separated by
// pseudo-random segment lengths. The line is then held steady for a fixed
// settle period, after which a one-cycle done pulse is issued.
//
// Ports:
//   CLK        in   system clock, all state updates on posedge
//   RST_N      in   asynchronous active-low reset
//   start      in   single-cycle request, honoured only while idle
//   target     in   requested final level, sampled together with start
//   switch_out out  emulated bouncing switch line (registered)
//   busy       out  high while bouncing or settling
//   done       out  one-cycle completion pulse
//
// Build option:
//   BOUNCE_DETERMINISTIC_EN  when defined, every request produces exactly
//                            2*BOUNCES_MAX+1 toggles spaced 2^GLITCH_BITS
//                            cycles apart. The LFSR keeps running but no
//                            longer influences the outputs.
// -----------------------------------------------------------------------------
module bounce_gen #(
    parameter logic        INIT_LEVEL    = 1'b1,
    parameter int          BOUNCES_MAX   = 8,
    parameter int          GLITCH_BITS   = 10,
    parameter int          SETTLE_CYCLES = 50000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic start,
    input  logic target,
    output logic switch_out,
    output logic busy,
    output logic done
);

    // toggles_left never exceeds 2*BOUNCES_MAX (the entry toggle is taken
    // in the same edge that accepts the request).
    localparam int              TL_W        = $clog2(2 * BOUNCES_MAX + 1);
    localparam int              ST_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [ST_W-1:0] SETTLE_LOAD = ST_W'(SETTLE_CYCLES - 1);
    localparam logic [15:0]     LFSR_TAPS   = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        SETTLE
    } state_t;

    state_t                 state_q,  state_d;
    logic                   sw_q,     sw_d;
    logic                   busy_q,   busy_d;
    logic                   done_q,   done_d;
    logic                   tgt_q,    tgt_d;
    logic [TL_W-1:0]        tl_q,     tl_d;
    logic [GLITCH_BITS-1:0] seg_q,    seg_d;
    logic [ST_W-1:0]        settle_q, settle_d;
    logic [15:0]            lfsr_q,   lfsr_d;

    // Load values for a new burst / the next segment.
    logic [TL_W-1:0]        tl_load;
    logic [GLITCH_BITS-1:0] seg_load;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

`ifdef BOUNCE_DETERMINISTIC_EN
    assign tl_load  = TL_W'(2 * BOUNCES_MAX);
    assign seg_load = '1;
`else
    // n = (LFSR & (BOUNCES_MAX-1)) + 1; 2*n toggles follow the entry toggle.
    logic [15:0] n_rand;
    assign n_rand   = (lfsr_q & 16'(BOUNCES_MAX - 1)) + 16'd1;
    assign tl_load  = TL_W'({n_rand, 1'b0});
    assign seg_load = lfsr_q[GLITCH_BITS-1:0];
`endif

    assign lfsr_d = lfsr_next(lfsr_q);

    // ---- state register -----------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            sw_q     <= INIT_LEVEL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tgt_q    <= INIT_LEVEL;
            tl_q     <= '0;
            seg_q    <= '0;
            settle_q <= '0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            state_q  <= state_d;
            sw_q     <= sw_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tgt_q    <= tgt_d;
            tl_q     <= tl_d;
            seg_q    <= seg_d;
            settle_q <= settle_d;
            lfsr_q   <= lfsr_d;
        end
    end

    // ---- next-state logic ---------------------------------------------------
    always_comb begin
        state_d  = state_q;
        sw_d     = sw_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tgt_d    = tgt_q;
        tl_d     = tl_q;
        seg_d    = seg_q;
        settle_d = settle_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (target == sw_q) begin
                        // Already at the requested level: acknowledge only.
                        done_d = 1'b1;
                    end else begin
                        // The entry toggle is applied on the accepting edge so
                        // the first BOUNCE cycle already shows the new level.
                        tgt_d   = target;
                        sw_d    = ~sw_q;
                        tl_d    = tl_load;
                        seg_d   = seg_load;
                        busy_d  = 1'b1;
                        state_d = BOUNCE;
                    end
                end
            end

            BOUNCE: begin
                if (seg_q == '0) begin
                    tl_d  = tl_q - TL_W'(1);
                    seg_d = seg_load;
                    if (tl_q == TL_W'(1)) begin
                        // Last toggle: parity puts us on the target, drive it
                        // explicitly so the final level is never in doubt.
                        sw_d     = tgt_q;
                        settle_d = SETTLE_LOAD;
                        state_d  = SETTLE;
                    end else begin
                        sw_d = ~sw_q;
                    end
                end else begin
                    seg_d = seg_q - GLITCH_BITS'(1);
                end
            end

            SETTLE: begin
                if (settle_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    settle_d = settle_q - ST_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign switch_out = sw_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_bounce_gen.sv
// -----------------------------------------------------------------------------
// tb_bounce_gen -- directed self-checking bench for bounce_gen.
// Uses a small configuration (BOUNCES_MAX=4, GLITCH_BITS=3, SETTLE_CYCLES=20)
// so that 200 random transitions stay short. With BOUNCE_DETERMINISTIC_EN
// defined, the exact 9-toggle / 8-cycle-spacing pattern is required.
// -----------------------------------------------------------------------------
module tb_bounce_gen;

    localparam int          BM     = 4;
    localparam int          GB     = 3;
    localparam int          SC     = 20;
    localparam logic        INIT   = 1'b1;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam int          SEGMAX = 1 << GB;
    localparam int          DEB    = 10;   // debouncer stability window (> SEGMAX, < SC)
`ifdef BOUNCE_DETERMINISTIC_EN
    localparam bit          DET    = 1'b1;
`else
    localparam bit          DET    = 1'b0;
`endif

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic start  = 1'b0;
    logic target = 1'b1;
    logic switch_out, busy, done;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    bounce_gen #(
        .INIT_LEVEL   (INIT),
        .BOUNCES_MAX  (BM),
        .GLITCH_BITS  (GB),
        .SETTLE_CYCLES(SC),
        .LFSR_SEED    (SEED)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .start     (start),
        .target    (target),
        .switch_out(switch_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference Galois LFSR (taps 16'hB400, right shift), free-running from reset.
    logic [15:0] lfsr_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= SEED;
        else        lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end

    // Loopback debouncer: commits a new level after DEB stable cycles.
    logic deb_q;
    int   deb_cnt;
    int   deb_events = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q   <= INIT;
            deb_cnt <= 0;
        end else if (switch_out !== deb_q) begin
            if (deb_cnt == DEB - 1) begin
                deb_q      <= switch_out;
                deb_cnt    <= 0;
                deb_events <= deb_events + 1;
            end else begin
                deb_cnt <= deb_cnt + 1;
            end
        end else begin
            deb_cnt <= 0;
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (switch_out !== INIT) begin
            n_fail++;
            $display("FAIL reset.switch_out: got %b, expected %b", switch_out, INIT);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset.busy: got %b, expected 0", busy);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset.done: got %b, expected 0", done);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_noop();
        int bad = 0;
        start  = 1'b1;
        target = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL noop.done: got %b, expected 1", done);
        end
        n_cmp++;
        if (busy !== 1'b0 || switch_out !== 1'b1) begin
            n_fail++;
            $display("FAIL noop.busy_sw: got busy=%b sw=%b, expected busy=0 sw=1", busy, switch_out);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || switch_out !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL noop.quiet: got %0d bad cycles, expected 0", bad);
        end
    endtask

    // One request from the current level to tgt. Returns at the negedge of the
    // cycle in which done is high, so a following call issues a back-to-back start.
    task automatic test_transition(input logic tgt, input bit poke_mid, input string name);
        int   t, ntog, t_first, t_last, t_done, gmin, gmax, busy_cnt, exp_tog, deb0, gap_lo;
        logic prev;
        ntog     = 0;
        t_first  = -1;
        t_last   = -1;
        t_done   = -1;
        gmin     = 1 << 30;
        gmax     = 0;
        busy_cnt = 0;
        gap_lo   = DET ? SEGMAX : 1;
        exp_tog  = DET ? (2 * BM + 1) : (2 * (int'(lfsr_m & 16'(BM - 1)) + 1) + 1);
        deb0     = deb_events;
        prev     = switch_out;
        t        = cyc;
        start    = 1'b1;
        target   = tgt;
        @(negedge clk);
        start  = 1'b0;
        target = ~tgt;   // must be ignored while busy
        for (int k = 1; k <= 400; k++) begin
            if (poke_mid && k == 3) begin
                start  = 1'b1;
                target = ~tgt;
            end
            if (poke_mid && k == 4) start = 1'b0;
            if (switch_out !== prev) begin
                ntog++;
                if (ntog == 1) begin
                    t_first = t + k;
                end else begin
                    if (t + k - t_last < gmin) gmin = t + k - t_last;
                    if (t + k - t_last > gmax) gmax = t + k - t_last;
                end
                t_last = t + k;
                prev   = switch_out;
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                t_done = t + k;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (t_done < 0) begin
            n_fail++;
            $display("FAIL %s.timeout: got no done in 400 cycles, expected done", name);
        end
        n_cmp++;
        if (ntog != exp_tog) begin
            n_fail++;
            $display("FAIL %s.toggles: got %0d, expected %0d", name, ntog, exp_tog);
        end
        n_cmp++;
        if (t_first != t + 1) begin
            n_fail++;
            $display("FAIL %s.first_toggle: got cycle %0d, expected %0d", name, t_first, t + 1);
        end
        n_cmp++;
        if (gmin < gap_lo || gmax > SEGMAX) begin
            n_fail++;
            $display("FAIL %s.gaps: got %0d..%0d, expected within %0d..%0d", name, gmin, gmax, gap_lo, SEGMAX);
        end
        n_cmp++;
        if (t_done != t_last + SC) begin
            n_fail++;
            $display("FAIL %s.done_time: got cycle %0d, expected %0d", name, t_done, t_last + SC);
        end
        n_cmp++;
        if (busy_cnt != t_done - t - 1) begin
            n_fail++;
            $display("FAIL %s.busy_cycles: got %0d, expected %0d", name, busy_cnt, t_done - t - 1);
        end
        n_cmp++;
        if (switch_out !== tgt) begin
            n_fail++;
            $display("FAIL %s.final_level: got %b, expected %b", name, switch_out, tgt);
        end
        n_cmp++;
        if (deb_events != deb0 + 1) begin
            n_fail++;
            $display("FAIL %s.debounced_events: got %0d, expected %0d", name, deb_events - deb0, 1);
        end
    endtask

    task automatic test_single();
        test_transition(1'b0, 1'b0, "single");
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL single.done_width: got %b, expected 0", done);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ignored_start();
        test_transition(1'b1, 1'b0, "rise");
        repeat (3) @(negedge clk);
        test_transition(1'b0, 1'b1, "ignored");
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        test_transition(~switch_out, 1'b0, "b2b_a");
        test_transition(~switch_out, 1'b0, "b2b_b");
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b.idle_after: got done=%b busy=%b, expected 0/0", done, busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            test_transition(~switch_out, 1'b0, "random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        start  = 1'b1;
        target = ~switch_out;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid.busy_before: got %b, expected 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (switch_out !== INIT || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid.async: got sw=%b busy=%b done=%b, expected %b/0/0",
                     switch_out, busy, done, INIT);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || switch_out !== INIT) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_mid.quiet_after: got %0d bad cycles, expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_noop();
        test_single();
        test_ignored_start();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bounce_gen.md
Name: bounce_gen

Overview:
- Synthesisable mechanical-switch emulator: the transmit-side counterpart of the debouncer.
- On request, drives a single-bit "switch" line from its current level to a target level through a burst of pseudo-random glitches, then holds the line steady.
- Used in on-board loopback and self-test builds to exercise debouncer instances without a physical button, and as a reusable stimulus source in benches.

Parameters:
- INIT_LEVEL, 1, level of switch_out after reset (1 = released, pulled-up switch).
- BOUNCES_MAX, 8, upper bound on bounce pairs per transition; must be a power of two, range 1..64.
- GLITCH_BITS, 10, width of the random segment-length field; each segment lasts 1..2^GLITCH_BITS cycles.
- SETTLE_CYCLES, 50000, cycles switch_out is held at target after the final toggle before done.
- LFSR_SEED, 16'hACE1, reset value of the internal LFSR; must be non-zero.

Ports:
- CLK  input  1  system clock.
- RST_N  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a transition; sampled only in IDLE.
- target  input  1  requested final level of switch_out; sampled with start.
- switch_out  output  1  emulated bouncing switch line, registered.
- busy  output  1  high while a transition is in progress (BOUNCE or SETTLE).
- done  output  1  one-cycle pulse when a request completes.

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low on RST_N. All state is updated on the posedge CLK.
- Reset values: switch_out=INIT_LEVEL, busy=0, done=0, state=IDLE, LFSR=LFSR_SEED, counters=0.
- LFSR: 16-bit Galois, taps mask 16'hB400, right-shift.
  - Advances every clock in every state and is never reloaded except by reset, so sequences are reproducible from reset.
  - Fields are taken from the value present in the cycle of use.
- States: IDLE, BOUNCE, SETTLE.
- IDLE, start=1, target==switch_out: no toggle. done=1 in the next cycle. busy stays 0. Remain in IDLE.
- IDLE, start=1, target!=switch_out:
  - Latch target.
  - Load toggles_left = 2*n+1, where n = (LFSR & (BOUNCES_MAX-1)) + 1, giving 3..2*BOUNCES_MAX+1 toggles.
  - Go to BOUNCE with seg_cnt=0.
  - busy=1 from the next cycle.
  - switch_out makes its first toggle on the first BOUNCE cycle.
- BOUNCE:
  - On entry and whenever seg_cnt reaches 0: toggle switch_out, decrement toggles_left, load seg_cnt = LFSR[GLITCH_BITS-1:0].
  - Consecutive toggles are therefore seg_cnt+1 cycles apart.
  - After the toggle that takes toggles_left to 0 (switch_out==target by parity), go to SETTLE with settle_cnt = SETTLE_CYCLES-1.
- SETTLE: switch_out is held. Decrement settle_cnt each cycle. At 0: done=1 for one cycle, busy=0 on the same edge, return to IDLE.
- start while busy: ignored, no queuing. target changes while busy are ignored.
- start and done can coincide only in IDLE. A new start is accepted in the cycle done is high.
- Reset mid-operation: immediate return to reset values. No done is generated.
- Counters size to their parameter maximum. No wrap is possible in legal configurations.

Optional Feature:
- Macro: BOUNCE_DETERMINISTIC_EN.
- Defined:
  - n is fixed at BOUNCES_MAX, giving exactly 2*BOUNCES_MAX+1 toggles.
  - Every segment is fixed at 2^GLITCH_BITS cycles (seg_cnt loads all-ones).
  - The LFSR still runs but does not influence outputs. Intended for benches and scope measurement.
- Undefined: random behaviour as above.

Test Plan:
- Reset check: assert RST_N=0 mid-BOUNCE -> switch_out=INIT_LEVEL, busy=0, done=0 asynchronously. No done after release.
- Deterministic transition, with BOUNCE_DETERMINISTIC_EN, BOUNCES_MAX=4, GLITCH_BITS=3, SETTLE_CYCLES=20, INIT_LEVEL=1. Pulse start with target=0 at cycle t:
  - exactly 9 toggles at t+1, t+9, ..., t+65;
  - final level 0;
  - done high only at cycle t+85;
  - busy high t+1..t+84.
- No-op request: target==switch_out=1, start at t -> done at t+1, busy never high, switch_out never toggles.
- Ignored start: second start with target=1 issued during BOUNCE -> toggle count and done timing unchanged from the single-request case. switch_out ends at 0.
- Random mode, defaults, 200 transitions alternating target:
  - toggle count is odd and in 3..17 each time;
  - every inter-toggle gap is in 1..1024;
  - final level equals target;
  - the hold after the final toggle before done is exactly 50000 cycles.
- Back-to-back: start in the cycle done is high -> accepted, busy high the next cycle. Loopback through a debouncer produces exactly one transition event per request.
